accelerator_matrix_vector_convolution_engine: RTL and testbench

//   Row-wise 1-D convolution of a streamed matrix A (SIZE_I x SIZE_J) with a vector B (SIZE_B).

---
 rtl/accelerator_matrix_vector_convolution_engine.sv | 181 ++++++++++++++++++
 tb/tb_accelerator_matrix_vector_convolution_engine.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accelerator_matrix_vector_convolution_engine.sv
// Row-wise 1-D convolution engine: each streamed row of A is convolved with
// vector B using a signed fixed-point MAC. The result saturates to DATA_SIZE bits
// when it is emitted.
//
// State table
//   IDLE   | wait for START; latch sizes and mode, or reject the job
//   LOAD_B | store SIZE_B elements of B
//   LOAD_A | store one row of SIZE_J elements of A
//   MAC    | SIZE_B cycles, one product B[m]*A[k-m] per cycle
//   EMIT   | present the saturated result, clear the accumulator
//   DONE   | one-cycle READY pulse
//
// Ports
//   CLK, RST                  clock, synchronous active-high reset
//   START, MODE               job start pulse; 0 = FULL, 1 = VALID
//   SIZE_I_IN/J_IN/B_IN       rows of A, columns of A, length of B
//   DATA_A_IN(_ENABLE)        A elements in row-major order
//   DATA_B_IN(_ENABLE)        B elements, index 0 first
//   READY, ERROR              job finished / last job rejected
//   DATA_OUT                  result element (holds between emissions)
//   DATA_OUT_SCALAR_ENABLE    DATA_OUT valid
//   DATA_OUT_VECTOR_ENABLE    last element of an output row
module accelerator_matrix_vector_convolution_engine #(
    parameter int DATA_SIZE = 16,
    parameter int MAX_SIZE  = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 START,
    output logic                 READY,
    output logic                 ERROR,
    input  logic                 MODE,
    input  logic [DATA_SIZE-1:0] SIZE_I_IN,
    input  logic [DATA_SIZE-1:0] SIZE_J_IN,
    input  logic [DATA_SIZE-1:0] SIZE_B_IN,
    input  logic                 DATA_A_IN_ENABLE,
    input  logic [DATA_SIZE-1:0] DATA_A_IN,
    input  logic                 DATA_B_IN_ENABLE,
    input  logic [DATA_SIZE-1:0] DATA_B_IN,
    output logic [DATA_SIZE-1:0] DATA_OUT,
    output logic                 DATA_OUT_SCALAR_ENABLE,
    output logic                 DATA_OUT_VECTOR_ENABLE
);
    localparam int AW   = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1;
    // k reaches up to 2*MAX_SIZE-2, so counters carry two extra bits
    localparam int CW   = AW + 2;
    localparam int PW   = 2 * DATA_SIZE;
    localparam int ACCW = PW + $clog2(MAX_SIZE);
    localparam logic signed [ACCW-1:0] SAT_HI = {{(ACCW-DATA_SIZE+1){1'b0}}, {(DATA_SIZE-1){1'b1}}};
    localparam logic signed [ACCW-1:0] SAT_LO = {{(ACCW-DATA_SIZE+1){1'b1}}, {(DATA_SIZE-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, LOAD_B, LOAD_A, MAC, EMIT, DONE} state_t;
    state_t state, state_next;

    logic                        mode;
    logic                        error_r;
    logic [DATA_SIZE-1:0]        size_i, row;
    logic [CW-1:0]               size_j, size_b, cnt, k, m;
    logic signed [DATA_SIZE-1:0] a_buf [MAX_SIZE];
    logic signed [DATA_SIZE-1:0] b_buf [MAX_SIZE];
    logic signed [ACCW-1:0]      acc;
    logic [DATA_SIZE-1:0]        hold;

    logic                        reject;
    logic [CW-1:0]               first_k, last_k;
    logic signed [CW:0]          idx;
    logic                        a_valid;
    logic signed [DATA_SIZE-1:0] a_term;
    logic signed [PW-1:0]        prod;
    logic [DATA_SIZE-1:0]        sat_val;

    assign reject = (SIZE_I_IN == '0) || (SIZE_J_IN == '0) || (SIZE_B_IN == '0) ||
                    (SIZE_J_IN > DATA_SIZE'(MAX_SIZE)) || (SIZE_B_IN > DATA_SIZE'(MAX_SIZE)) ||
                    (MODE && (SIZE_J_IN < SIZE_B_IN));

    assign first_k = mode ? (size_b - CW'(1)) : '0;
    assign last_k  = mode ? (size_j - CW'(1)) : (size_j + size_b - CW'(2));

    // A index k-m; negative or >= SIZE_J means the zero-padded region
    assign idx     = $signed({1'b0, k}) - $signed({1'b0, m});
    assign a_valid = !idx[CW] && (idx[CW-1:0] < size_j);
    assign a_term  = a_valid ? a_buf[idx[AW-1:0]] : '0;
    assign prod    = PW'(a_term) * PW'(b_buf[m[AW-1:0]]);

    assign sat_val = (acc > SAT_HI) ? SAT_HI[DATA_SIZE-1:0] :
                     (acc < SAT_LO) ? SAT_LO[DATA_SIZE-1:0] : acc[DATA_SIZE-1:0];

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (START) state_next = reject ? DONE : LOAD_B;
            LOAD_B: if (DATA_B_IN_ENABLE && (cnt == size_b - CW'(1))) state_next = LOAD_A;
            LOAD_A: if (DATA_A_IN_ENABLE && (cnt == size_j - CW'(1))) state_next = MAC;
            MAC:    if (m == size_b - CW'(1)) state_next = EMIT;
            EMIT: begin
                if (k != last_k)                       state_next = MAC;
                else if (row != size_i - DATA_SIZE'(1)) state_next = LOAD_A;
                else                                   state_next = DONE;
            end
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        READY                  = (state == DONE);
        DATA_OUT_SCALAR_ENABLE = (state == EMIT);
        DATA_OUT_VECTOR_ENABLE = (state == EMIT) && (k == last_k);
        DATA_OUT               = (state == EMIT) ? sat_val : hold;
        ERROR                  = error_r;
    end

    // Buffers are not reset; they are always fully rewritten before use.
    always_ff @(posedge CLK) begin
        if (state == LOAD_B && DATA_B_IN_ENABLE) b_buf[cnt[AW-1:0]] <= DATA_B_IN;
        if (state == LOAD_A && DATA_A_IN_ENABLE) a_buf[cnt[AW-1:0]] <= DATA_A_IN;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode    <= 1'b0;
            error_r <= 1'b0;
            size_i  <= '0;
            size_j  <= '0;
            size_b  <= '0;
            row     <= '0;
            cnt     <= '0;
            k       <= '0;
            m       <= '0;
            acc     <= '0;
            hold    <= '0;
        end else begin
            case (state)
                IDLE: if (START) begin
                    error_r <= reject;
                    if (!reject) begin
                        mode   <= MODE;
                        size_i <= SIZE_I_IN;
                        size_j <= CW'(SIZE_J_IN);
                        size_b <= CW'(SIZE_B_IN);
                        row    <= '0;
                        cnt    <= '0;
                        acc    <= '0;
                    end
                end
                LOAD_B: if (DATA_B_IN_ENABLE) begin
                    cnt <= (cnt == size_b - CW'(1)) ? '0 : cnt + CW'(1);
                end
                LOAD_A: if (DATA_A_IN_ENABLE) begin
                    if (cnt == size_j - CW'(1)) begin
                        cnt <= '0;
                        k   <= first_k;
                        m   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                MAC: begin
                    acc <= acc + ACCW'(prod);
                    m   <= m + CW'(1);
                end
                EMIT: begin
                    hold <= sat_val;
                    acc  <= '0;
                    m    <= '0;
                    if (k != last_k) k <= k + CW'(1);
                    else if (row != size_i - DATA_SIZE'(1)) begin
                        row <= row + DATA_SIZE'(1);
                        cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_accelerator_matrix_vector_convolution_engine.sv
module tb_accelerator_matrix_vector_convolution_engine;
    logic        CLK = 1'b0;
    logic        RST, START, MODE;
    logic [15:0] SIZE_I_IN, SIZE_J_IN, SIZE_B_IN;
    logic        DATA_A_IN_ENABLE, DATA_B_IN_ENABLE;
    logic [15:0] DATA_A_IN, DATA_B_IN, DATA_OUT;
    logic        READY, ERROR, DATA_OUT_SCALAR_ENABLE, DATA_OUT_VECTOR_ENABLE;

    accelerator_matrix_vector_convolution_engine #(.DATA_SIZE(16), .MAX_SIZE(8)) dut (
        .CLK(CLK), .RST(RST), .START(START), .READY(READY), .ERROR(ERROR), .MODE(MODE),
        .SIZE_I_IN(SIZE_I_IN), .SIZE_J_IN(SIZE_J_IN), .SIZE_B_IN(SIZE_B_IN),
        .DATA_A_IN_ENABLE(DATA_A_IN_ENABLE), .DATA_A_IN(DATA_A_IN),
        .DATA_B_IN_ENABLE(DATA_B_IN_ENABLE), .DATA_B_IN(DATA_B_IN),
        .DATA_OUT(DATA_OUT), .DATA_OUT_SCALAR_ENABLE(DATA_OUT_SCALAR_ENABLE),
        .DATA_OUT_VECTOR_ENABLE(DATA_OUT_VECTOR_ENABLE)
    );

    always #5 CLK = ~CLK;

    int checks = 0, errors = 0;
    int cyc = 0;
    int out_val[$];
    int out_vec[$];
    int out_t[$];
    int vec_cnt = 0, ready_cnt = 0, ready_t = 0;
    int start_t = 0, a_last_t = 0;
    int a_v[16];
    int b_v[16];

    always @(posedge CLK) cyc++;

    always @(negedge CLK) begin
        if (DATA_OUT_SCALAR_ENABLE) begin
            out_val.push_back(int'($signed(DATA_OUT)));
            out_vec.push_back(int'(DATA_OUT_VECTOR_ENABLE));
            out_t.push_back(cyc);
            if (DATA_OUT_VECTOR_ENABLE) vec_cnt++;
        end
        if (READY) begin
            ready_cnt++;
            ready_t = cyc;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_job(input bit md, input int ni, input int nj, input int nl);
        @(negedge CLK);
        MODE = md; SIZE_I_IN = 16'(ni); SIZE_J_IN = 16'(nj); SIZE_B_IN = 16'(nl);
        START = 1'b1;
        start_t = cyc;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic load_b(input int nl);
        for (int n = 0; n < nl; n++) begin
            @(negedge CLK);
            DATA_B_IN_ENABLE = 1'b1; DATA_B_IN = 16'(b_v[n]);
        end
        @(negedge CLK);
        DATA_B_IN_ENABLE = 1'b0;
    endtask

    task automatic load_row(input int r, input int nj);
        for (int n = 0; n < nj; n++) begin
            @(negedge CLK);
            DATA_A_IN_ENABLE = 1'b1; DATA_A_IN = 16'(a_v[r*nj+n]);
            if (r == 0 && n == nj - 1) a_last_t = cyc;
        end
        @(negedge CLK);
        DATA_A_IN_ENABLE = 1'b0;
    endtask

    task automatic wait_vec(input int target);
        int n = 0;
        while (vec_cnt < target && n < 300) begin @(posedge CLK); n++; end
        chk("row_done_timeout", int'(vec_cnt >= target), 1);
    endtask

    task automatic wait_ready(input int target);
        int n = 0;
        while (ready_cnt < target && n < 300) begin @(posedge CLK); n++; end
        chk("ready_timeout", int'(ready_cnt >= target), 1);
        @(negedge CLK);
    endtask

    task automatic clear_log();
        out_val.delete(); out_vec.delete(); out_t.delete();
    endtask

    task automatic run_job(input bit md, input int ni, input int nj, input int nl);
        int vb, rb;
        vb = vec_cnt; rb = ready_cnt;
        clear_log();
        start_job(md, ni, nj, nl);
        load_b(nl);
        for (int r = 0; r < ni; r++) begin
            load_row(r, nj);
            if (r < ni - 1) wait_vec(vb + r + 1);
        end
        wait_ready(rb + 1);
    endtask

    task automatic set_t1();
        a_v[0] = 1; a_v[1] = 2; a_v[2] = 3;
        b_v[0] = 1; b_v[1] = 1;
    endtask

    // FULL, J=3, L=2, A=[1,2,3], B=[1,1] -> 1,3,5,3
    task automatic check_t1(input string tag);
        chk({tag, "_count"}, out_val.size(), 4);
        if (out_val.size() == 4) begin
            chk({tag, "_y0"}, out_val[0], 1);
            chk({tag, "_y1"}, out_val[1], 3);
            chk({tag, "_y2"}, out_val[2], 5);
            chk({tag, "_y3"}, out_val[3], 3);
            chk({tag, "_vec"}, out_vec[0] + out_vec[1] + out_vec[2], 0);
            chk({tag, "_vec_last"}, out_vec[3], 1);
            chk({tag, "_latency"}, out_t[0] - a_last_t, 3);
            chk({tag, "_gap1"}, out_t[1] - out_t[0], 3);
            chk({tag, "_gap3"}, out_t[3] - out_t[2], 3);
            chk({tag, "_ready_after"}, ready_t - out_t[3], 1);
        end
        chk({tag, "_error"}, int'(ERROR), 0);
    endtask

    task automatic reject_job(input string tag, input bit md, input int ni, input int nj, input int nl);
        int rb, ob;
        rb = ready_cnt; ob = out_val.size();
        start_job(md, ni, nj, nl);
        wait_ready(rb + 1);
        repeat (3) @(negedge CLK);
        chk({tag, "_error"}, int'(ERROR), 1);
        chk({tag, "_ready_next"}, ready_t - start_t, 1);
        chk({tag, "_ready_once"}, ready_cnt, rb + 1);
        chk({tag, "_no_output"}, out_val.size(), ob);
    endtask

    initial begin
        int rb;
        RST = 1'b1; START = 1'b0; MODE = 1'b0;
        SIZE_I_IN = '0; SIZE_J_IN = '0; SIZE_B_IN = '0;
        DATA_A_IN_ENABLE = 1'b0; DATA_B_IN_ENABLE = 1'b0;
        DATA_A_IN = '0; DATA_B_IN = '0;
        repeat (3) @(negedge CLK);
        chk("rst_ready", int'(READY), 0);
        chk("rst_error", int'(ERROR), 0);
        chk("rst_data", int'(DATA_OUT), 0);
        chk("rst_scalar", int'(DATA_OUT_SCALAR_ENABLE), 0);
        chk("rst_vector", int'(DATA_OUT_VECTOR_ENABLE), 0);
        RST = 1'b0;

        // Test 1: basic FULL job
        set_t1();
        run_job(1'b0, 1, 3, 2);
        check_t1("t1");
        repeat (4) @(negedge CLK);
        chk("t1_hold", int'($signed(DATA_OUT)), 3);
        chk("t1_scalar_idle", int'(DATA_OUT_SCALAR_ENABLE), 0);

        // Test 2: VALID, two rows, B=[1,-1]
        a_v[0] = 1; a_v[1] = 2; a_v[2] = 3; a_v[3] = 4; a_v[4] = 5; a_v[5] = 6;
        b_v[0] = 1; b_v[1] = -1;
        run_job(1'b1, 2, 3, 2);
        chk("t2_count", out_val.size(), 4);
        if (out_val.size() == 4) begin
            for (int n = 0; n < 4; n++) begin
                chk($sformatf("t2_y%0d", n), out_val[n], 1);
                chk($sformatf("t2_vec%0d", n), out_vec[n], n % 2);
            end
        end
        chk("t2_error", int'(ERROR), 0);

        // Test 3: saturation in both directions
        a_v[0] = 32767; b_v[0] = 2;
        run_job(1'b0, 1, 1, 1);
        chk("t3_pos_count", out_val.size(), 1);
        if (out_val.size() == 1) begin
            chk("t3_pos_sat", out_val[0], 32767);
            chk("t3_pos_vec", out_vec[0], 1);
        end
        a_v[0] = -32768; b_v[0] = 2;
        run_job(1'b0, 1, 1, 1);
        chk("t3_neg_count", out_val.size(), 1);
        if (out_val.size() == 1) chk("t3_neg_sat", out_val[0], -32768);

        // Test 5: START pulses during LOAD_A and MAC are ignored
        set_t1();
        clear_log();
        rb = ready_cnt;
        start_job(1'b0, 1, 3, 2);
        load_b(2);
        START = 1'b1; SIZE_B_IN = 16'd0; SIZE_J_IN = 16'd7; MODE = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        load_row(0, 3);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_ready(rb + 1);
        check_t1("t5");
        repeat (4) @(negedge CLK);
        chk("t5_ready_once", ready_cnt, rb + 1);

        // Test 6: reset during MAC, then a fresh job
        clear_log();
        rb = ready_cnt;
        start_job(1'b0, 1, 3, 2);
        load_b(2);
        load_row(0, 3);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("t6_rst_data", int'(DATA_OUT), 0);
        chk("t6_rst_scalar", int'(DATA_OUT_SCALAR_ENABLE), 0);
        chk("t6_rst_ready", int'(READY), 0);
        repeat (10) @(negedge CLK);
        chk("t6_no_output", out_val.size(), 0);
        chk("t6_no_ready", ready_cnt, rb);
        run_job(1'b0, 1, 3, 2);
        check_t1("t6");

        // Test 4: rejected jobs
        reject_job("t4_b0", 1'b0, 1, 3, 0);
        reject_job("t4_j9", 1'b0, 1, 9, 2);
        reject_job("t4_valid", 1'b1, 1, 2, 3);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("t4_rst_error", int'(ERROR), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
